// File: rtl/riscv_pkg.sv
// riscv_pkg: loader FSM states and image-format constants shared by prog_loader and word_assembler.
package riscv_pkg;
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} state_e;
  localparam int HDR_LEN    = 2;
  localparam int CSUM_BITS  = 8;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs little-endian bytes into 32-bit words and keeps the running XOR checksum.
module word_assembler
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [7:0]           byte_i,
  output logic                 word_done_o,
  output logic [31:0]          word_o,
  output logic [CSUM_BITS-1:0] csum_o
);
  logic [$clog2(WORD_BYTES)-1:0] idx_q, idx_d;
  logic [23:0] lo_q, lo_d;
  logic [CSUM_BITS-1:0] csum_q, csum_d;
  always_comb begin
    idx_d  = clr_i ? '0 : en_i ? idx_q + 1'b1 : idx_q;
    csum_d = clr_i ? '0 : en_i ? csum_q ^ byte_i : csum_q;
    lo_d   = lo_q;
    if (en_i && idx_q != 2'd3) lo_d[idx_q*8 +: 8] = byte_i;
    if (clr_i) lo_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      lo_q   <= '0;
      csum_q <= '0;
    end else begin
      idx_q  <= idx_d;
      lo_q   <= lo_d;
      csum_q <= csum_d;
    end
  end
  // The last byte goes straight to the output so the word is ready in the same cycle.
  assign word_done_o = en_i && idx_q == 2'd3;
  assign word_o      = {byte_i, lo_q};
  assign csum_o      = csum_q;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, XOR-checked byte image, writes it into
// instruction memory and releases the core reset once the image is verified.
module prog_loader
  import riscv_pkg::*;
#(
  parameter int i_addr_bits = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  input  logic                   restart,
  output logic                   i_wr_en,
  output logic [i_addr_bits-1:0] i_wr_addr,
  output logic [31:0]            i_wr_data,
  output logic                   core_rst_n,
  output logic                   load_done,
  output logic                   load_err
);
  localparam int CAP = 2 ** (i_addr_bits - 2);
  state_e state_q, state_d;
  logic [7:0] cnt_lo_q, cnt_lo_d;
  logic [15:0] n_q, n_d, widx_q, widx_d;
  logic [15:0] n_hdr;
  logic xfer, restart_go, clr, word_done;
  logic [31:0] word;
  logic [CSUM_BITS-1:0] csum;
  logic wr_en_q;
  logic [i_addr_bits-1:0] wr_addr_q;
  logic [31:0] wr_data_q;
  logic core_rst_n_q, done_q, err_q;
  assign byte_ready = state_q != DONE && state_q != ERR;
  assign xfer       = byte_valid && byte_ready;
  assign n_hdr      = {byte_data, cnt_lo_q};
  assign restart_go = restart && (state_q == DONE || state_q == ERR);
  // Checksum and byte index restart at the header boundary, so N==0 images check against 0.
  assign clr        = (state_q == HDR1 && xfer) || restart_go;
  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .en_i       (xfer && state_q == DATA),
    .byte_i     (byte_data),
    .word_done_o(word_done),
    .word_o     (word),
    .csum_o     (csum)
  );
  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    n_d      = n_q;
    widx_d   = widx_q;
    case (state_q)
      HDR0: if (xfer) begin
        cnt_lo_d = byte_data;
        state_d  = HDR1;
      end
      HDR1: if (xfer) begin
        n_d     = n_hdr;
        widx_d  = '0;
        state_d = n_hdr == 16'd0 ? CSUM : {16'd0, n_hdr} > 32'(CAP) ? ERR : DATA;
      end
      DATA: if (word_done) begin
        widx_d  = widx_q + 16'd1;
        state_d = widx_q == n_q - 16'd1 ? CSUM : DATA;
      end
      CSUM: if (xfer) state_d = byte_data == csum ? DONE : ERR;
      DONE, ERR: if (restart) begin
        state_d  = HDR0;
        cnt_lo_d = '0;
        n_d      = '0;
        widx_d   = '0;
      end
      default: state_d = HDR0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HDR0;
      cnt_lo_q     <= '0;
      n_q          <= '0;
      widx_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_lo_q     <= cnt_lo_d;
      n_q          <= n_d;
      widx_q       <= widx_d;
      wr_en_q      <= word_done;
      core_rst_n_q <= state_d == DONE;
      done_q       <= state_d == DONE;
      err_q        <= state_d == ERR;
      if (word_done) begin
        wr_addr_q <= {widx_q[i_addr_bits-3:0], 2'b00};
        wr_data_q <= word;
      end
    end
  end
  assign i_wr_en    = wr_en_q;
  assign i_wr_addr  = wr_addr_q;
  assign i_wr_data  = wr_data_q;
  assign core_rst_n = core_rst_n_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized and directed images checked against a byte-level image model via a write scoreboard.
module tb_prog_loader;
  localparam int AW  = 6;
  localparam int CAP = 2 ** (AW - 2);
  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic byte_ready;
  logic restart = 1'b0;
  logic i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [31:0] i_wr_data;
  logic core_rst_n, load_done, load_err;
  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];
  prog_loader #(.i_addr_bits(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .restart   (restart),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .core_rst_n(core_rst_n),
    .load_done (load_done),
    .load_err  (load_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && i_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", i_wr_addr, i_wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(i_wr_addr), 32'(e.a));
        check("wr_data", i_wr_data, e.d);
      end
    end
  end
  task automatic make_img(input int n, input bit bad, output logic [7:0] img[$]);
    logic [7:0] x;
    img = {};
    x = '0;
    img.push_back(8'(n));
    img.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      x ^= b;
      img.push_back(b);
    end
    img.push_back(bad ? x ^ 8'h01 : x);
  endtask
  task automatic send_byte(input logic [7:0] b, input bit rs);
    bit ok;
    byte_valid = 1'b1;
    byte_data  = b;
    restart    = rs;
    for (int t = 0; t < 20; t++) begin
      ok = byte_ready;
      @(posedge clk);
      #1;
      restart = 1'b0;
      if (ok) break;
      if (t == 19) begin
        checks++;
        errors++;
        $display("FAIL byte_accept: got no ready in 20 cycles expected acceptance");
      end
    end
    byte_valid = 1'b0;
  endtask
  // cut > 0 sends only the first cut bytes and then pulses rst_n.
  task automatic run_image(input logic [7:0] img[$], input bit gaps, input bit rnd_rs, input int cut);
    int n, nsend;
    logic [7:0] x;
    bit good;
    n = {img[1], img[0]};
    x = '0;
    for (int i = 0; i < 4 * n && n <= CAP; i++) x ^= img[2 + i];
    good  = n <= CAP && img[2 + 4 * n] == x;
    nsend = n > CAP ? 2 : img.size();
    if (cut > 0) nsend = cut;
    for (int w = 0; w < n && n <= CAP; w++)
      if (2 + 4 * w + 4 <= nsend)
        exp_q.push_back('{a: AW'(w * 4), d: {img[5 + 4 * w], img[4 + 4 * w], img[3 + 4 * w], img[2 + 4 * w]}});
    for (int i = 0; i < nsend; i++) begin
      send_byte(img[i], rnd_rs && ($urandom_range(0, 5) == 0));
      if (gaps) begin
        @(posedge clk);
        #1;
      end
    end
    if (cut > 0) begin
      rst_n = 1'b0;
      #2;
      check("rst_wr_en", 32'(i_wr_en), 0);
      check("rst_wr_addr", 32'(i_wr_addr), 0);
      check("rst_wr_data", i_wr_data, 0);
      check("rst_core_rst_n", 32'(core_rst_n), 0);
      check("rst_done_err", {load_done, load_err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_byte_ready", 32'(byte_ready), 1);
      check("rst_queue_empty", exp_q.size(), 0);
      return;
    end
    repeat (3) @(posedge clk);
    #1;
    check("load_done", 32'(load_done), 32'(good));
    check("load_err", 32'(load_err), 32'(!good));
    check("core_rst_n", 32'(core_rst_n), 32'(good));
    check("byte_ready_end", 32'(byte_ready), 0);
    check("writes_all_seen", exp_q.size(), 0);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    check("restart_done_err", {load_done, load_err}, 0);
    check("restart_core_rst_n", 32'(core_rst_n), 0);
    check("restart_ready", 32'(byte_ready), 1);
  endtask
  initial begin
    logic [7:0] img[$];
    logic [7:0] ref_img[$];
    #3;
    check("reset_wr_en", 32'(i_wr_en), 0);
    check("reset_core_rst_n", 32'(core_rst_n), 0);
    check("reset_done_err", {load_done, load_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ready", 32'(byte_ready), 1);
    ref_img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    run_image(ref_img, 1'b0, 1'b0, 0);
    img = ref_img;
    img[10] = 8'h81;
    run_image(img, 1'b0, 1'b0, 0);
    run_image(ref_img, 1'b1, 1'b0, 0);
    make_img(17, 1'b0, img);
    run_image(img, 1'b0, 1'b0, 0);
    make_img(0, 1'b0, img);
    run_image(img, 1'b0, 1'b0, 0);
    make_img(CAP, 1'b0, img);
    run_image(img, 1'b0, 1'b0, 0);
    run_image(ref_img, 1'b0, 1'b0, 7);
    run_image(ref_img, 1'b0, 1'b0, 0);
    for (int k = 0; k < 12; k++) begin
      make_img($urandom_range(0, CAP + 1), $urandom_range(0, 3) == 0, img);
      run_image(img, 1'($urandom_range(0, 1)), 1'b1, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
